// File: rtl/pe_result_if.sv
// Handshake bundle between the PE lane, the result packer and the register-file write port.
interface pe_result_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [1:0]        vsew;
  logic [1:0]        widening;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [BE_W-1:0]   out_be;
  logic              out_last;
  logic              eew_err;

  // Upstream PE lane plus downstream write port, seen from outside the packer
  modport master (
    output flush, in_valid, in_data, in_last, vsew, widening, out_ready,
    input  in_ready, out_valid, out_data, out_be, out_last, eew_err
  );

  // The packer itself
  modport slave (
    input  flush, in_valid, in_data, in_last, vsew, widening, out_ready,
    output in_ready, out_valid, out_data, out_be, out_last, eew_err
  );
endinterface

// File: rtl/pe_result_packer.sv
// Packs 8/16/32-bit PE results into dense 32-bit register-file write words with byte enables.
module pe_result_packer (
  input  logic          clk,
  input  logic          n_reset,
  pe_result_if.slave    bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [1:0] EEW_8  = 2'd0;
  localparam logic [1:0] EEW_16 = 2'd1;
  localparam logic [1:0] EEW_32 = 2'd2;

  logic [0:0]        state_q,     state_d;
  logic [1:0]        slot_q,      slot_d;
  logic [1:0]        eew_q,       eew_d;
  logic [DATA_W-1:0] acc_q,       acc_d;
  logic [BE_W-1:0]   acc_be_q,    acc_be_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [BE_W-1:0]   out_be_q,    out_be_d;
  logic              out_last_q,  out_last_d;
  logic              eew_err_q,   eew_err_d;

  logic [2:0]        req_code_c;
  logic              req_err_c;
  logic [1:0]        req_eew_c;
  logic [1:0]        cur_eew_c;
  logic [DATA_W-1:0] lane_data_c;
  logic [BE_W-1:0]   lane_be_c;
  logic              last_slot_c;
  logic              accept_c;

  // Handshake: ready whenever the output register is free or draining this cycle
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept_c     = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_be    = out_be_q;
  assign bus.out_last  = out_last_q;
  assign bus.eew_err   = eew_err_q;

  // Decode the requested effective element width; illegal combinations fall back to 32b
  always_comb begin
    req_code_c = {1'b0, bus.vsew};
    if (bus.widening == 2'd1) begin
      req_code_c = req_code_c + 3'd1;
    end else if (bus.widening == 2'd2) begin
      req_code_c = req_code_c + 3'd2;
    end
    req_err_c = (bus.vsew == 2'd3) | (bus.widening == 2'd3) | (req_code_c > 3'd2);
    req_eew_c = req_err_c ? EEW_32 : req_code_c[1:0];
  end

  // Place the incoming element in its slot; width comes from the inputs only when starting a word
  always_comb begin
    cur_eew_c   = (state_q == ST_IDLE) ? req_eew_c : eew_q;
    lane_data_c = '0;
    lane_be_c   = '0;
    last_slot_c = 1'b0;
    case (cur_eew_c)
      EEW_8: begin
        lane_data_c = DATA_W'(bus.in_data[7:0]) << {slot_q, 3'b000};
        lane_be_c   = BE_W'(4'b0001) << slot_q;
        last_slot_c = (slot_q == 2'd3);
      end
      EEW_16: begin
        lane_data_c = DATA_W'(bus.in_data[15:0]) << {slot_q[0], 4'b0000};
        lane_be_c   = BE_W'(4'b0011) << {slot_q[0], 1'b0};
        last_slot_c = slot_q[0];
      end
      default: begin
        lane_data_c = bus.in_data;
        lane_be_c   = '1;
        last_slot_c = 1'b1;
      end
    endcase
  end

  // Next-state: accumulate, complete words into the output register, flush
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    eew_d       = eew_q;
    acc_d       = acc_q;
    acc_be_d    = acc_be_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_last_d  = out_last_q;
    eew_err_d   = 1'b0;

    if (bus.flush) begin
      state_d     = ST_IDLE;
      slot_d      = 2'd0;
      acc_d       = '0;
      acc_be_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q & bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept_c) begin
        if (state_q == ST_IDLE) begin
          eew_d     = req_eew_c;
          eew_err_d = req_err_c;
        end
        if (last_slot_c | bus.in_last) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q | lane_data_c;
          out_be_d    = acc_be_q | lane_be_c;
          out_last_d  = bus.in_last;
          acc_d       = '0;
          acc_be_d    = '0;
          slot_d      = 2'd0;
          state_d     = ST_IDLE;
        end else begin
          acc_d    = acc_q | lane_data_c;
          acc_be_d = acc_be_q | lane_be_c;
          slot_d   = slot_q + 2'd1;
          state_d  = ST_FILL;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= 2'd0;
      eew_q       <= EEW_8;
      acc_q       <= '0;
      acc_be_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_last_q  <= 1'b0;
      eew_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      eew_q       <= eew_d;
      acc_q       <= acc_d;
      acc_be_q    <= acc_be_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_last_q  <= out_last_d;
      eew_err_q   <= eew_err_d;
    end
  end
endmodule

// File: tb/tb_pe_result_packer.sv
// Scoreboard bench for pe_result_packer: directed scenarios plus a randomized stream.
module tb_pe_result_packer;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  pe_result_if bus();

  pe_result_packer dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;
  int obs_err = 0;
  logic rand_ready = 1'b0;
  word_t exp_q[$];

  // Reference model state: the word currently being assembled, in bytes
  int          pos = 0;
  int          bpe = 4;
  logic [31:0] grp_data = '0;
  logic [3:0]  grp_be = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: consumes every accepted element and predicts completed words
  always @(negedge clk) begin
    int code;
    bit err;
    word_t w;
    if (!n_reset || bus.flush) begin
      pos = 0; grp_data = '0; grp_be = '0;
    end else if (bus.in_valid && bus.in_ready) begin
      if (pos == 0) begin
        code = int'(bus.vsew);
        if (bus.widening == 2'd1) code = code + 1;
        if (bus.widening == 2'd2) code = code + 2;
        err = (bus.vsew == 2'd3) || (bus.widening == 2'd3) || (code > 2);
        bpe = err ? 4 : (1 << code);
        if (err) exp_err++;
      end
      for (int b = 0; b < bpe; b++) begin
        grp_data[8*(pos+b) +: 8] = bus.in_data[8*b +: 8];
        grp_be[pos+b] = 1'b1;
      end
      pos = pos + bpe;
      if (pos == 4 || bus.in_last) begin
        w.data = grp_data; w.be = grp_be; w.last = bus.in_last;
        exp_q.push_back(w);
        pos = 0; grp_data = '0; grp_be = '0;
      end
    end
  end

  // Monitor: compares each word taken by the write port against the scoreboard
  always @(negedge clk) begin
    word_t e;
    if (n_reset) begin
      if (bus.eew_err) obs_err++;
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got %h be %h, scoreboard empty", bus.out_data, bus.out_be);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", bus.out_data, e.data);
          chk("word_be", 32'(bus.out_be), 32'(e.be));
          chk("word_last", 32'(bus.out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      tick(); @(negedge clk); n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_width(input logic [1:0] s, input logic [1:0] w);
    bus.vsew = s; bus.widening = w;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_out_be"}, 32'(bus.out_be), 32'd0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_eew_err"}, 32'(bus.eew_err), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.vsew = 2'd0; bus.widening = 2'd0; bus.out_ready = 1'b1;
    #2;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    n_reset = 1'b1;
    tick();
    check_zero_outputs("post_reset");

    // 8b stream: one word after the fourth element
    set_width(2'd0, 2'd0);
    send(32'hFFFF_FF11, 1'b0);
    send(32'h0000_0022, 1'b0);
    send(32'h1234_5633, 1'b0);
    @(negedge clk);
    chk("b8_not_early", 32'(bus.out_valid), 32'd0);
    tick();
    send(32'h0000_0044, 1'b0);
    @(negedge clk);
    chk("b8_latency_valid", 32'(bus.out_valid), 32'd1);
    chk("b8_word", bus.out_data, 32'h4433_2211);
    tick();

    // Widening 8b->16b with a short last word
    set_width(2'd0, 2'd1);
    send(32'h0000_AAAA, 1'b0);
    send(32'h0000_BBBB, 1'b0);
    send(32'h0000_CCCC, 1'b1);
    @(negedge clk);
    chk("wid_last_be", 32'(bus.out_be), 32'h3);
    chk("wid_last_flag", 32'(bus.out_last), 32'd1);
    tick();

    // Back-pressure with overlapping handshake at 32b
    set_width(2'd2, 2'd0);
    bus.out_ready = 1'b0;
    send(32'hA5A5_0001, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_0002; bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_data_held", bus.out_data, 32'hA5A5_0001);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid_kept", 32'(bus.out_valid), 32'd1);
    chk("bp_next_word", bus.out_data, 32'hA5A5_0002);
    tick();

    // Illegal width: one eew_err pulse, treated as 32b
    set_width(2'd2, 2'd2);
    send(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("err_pulse", 32'(bus.eew_err), 32'd1);
    chk("err_word", bus.out_data, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("err_one_cycle", 32'(bus.eew_err), 32'd0);
    tick();

    // Width changes mid-FILL are ignored
    set_width(2'd0, 2'd0);
    send(32'h0000_0055, 1'b0);
    set_width(2'd2, 2'd0);
    send(32'h0000_0066, 1'b0);
    send(32'h0000_0077, 1'b0);
    send(32'h0000_0088, 1'b0);
    @(negedge clk);
    chk("midfill_word", bus.out_data, 32'h8877_6655);
    chk("midfill_no_err", 32'(bus.eew_err), 32'd0);
    tick();

    // Flush drops the partial word and the element presented with it
    set_width(2'd0, 2'd0);
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h0000_0099;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    send(32'h0000_0003, 1'b1);
    @(negedge clk);
    chk("flush_word", bus.out_data, 32'h0000_0003);
    chk("flush_be", 32'(bus.out_be), 32'h1);
    tick();

    // Same with an asynchronous reset pulse
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b0);
    n_reset = 1'b0;
    #1;
    check_zero_outputs("midrst");
    tick();
    check_zero_outputs("midrst_hold");
    n_reset = 1'b1;
    tick();
    send(32'h0000_0003, 1'b1);
    @(negedge clk);
    chk("rst_word", bus.out_data, 32'h0000_0003);
    chk("rst_be", 32'(bus.out_be), 32'h1);
    chk("rst_last", 32'(bus.out_last), 32'd1);
    tick();

    // Randomized stream with back-pressure, gaps, width changes and occasional flush
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      set_width(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 39) == 0 && exp_q.size() == 0 && !bus.out_valid) begin
        bus.flush = 1'b1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data = $urandom;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
      end
      send($urandom, ($urandom_range(0, 5) == 0));
    end

    // Drain whatever is still pending
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(); n++;
    end
    tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("eew_err_count", 32'(obs_err), 32'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pe_result_packer.md
# pe_result_packer

Sits directly downstream of the 32-bit processing element array lane. It accepts one PE result per element over a valid/ready handshake and packs the narrow elements into 32-bit vector-register write words with byte enables, at the effective element width. It emits a word when the word fills or the instruction's last element arrives, so the register-file write port sees one dense word per write.

## Interface
Parameters: none; the datapath is fixed at 32 bits to match the PE output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- n_reset  input  1  reset, asynchronous and active-low.
- flush  input  1  synchronous abort; discards the partial word and the pending output word.
- in_valid  input  1  PE result valid.
- in_ready  output  1  packer can accept the result this cycle.
- in_data  input  32  PE result; the element occupies the low EEW bits, the upper bits are ignored.
- in_last  input  1  this element is the last of the instruction.
- vsew  input  2  SEW code: 0=8b, 1=16b, 2=32b, 3=reserved.
- widening  input  2  widening mode: 2'd1 widening, 2'd2 quad widening, 0 none.
- out_valid  output  1  a packed word is available.
- out_ready  input  1  the write port accepts the word.
- out_data  output  32  packed word.
- out_be  output  4  byte enables for out_data.
- out_last  output  1  the word holds the instruction's last element.
- eew_err  output  1  one-cycle pulse when an illegal width combination is latched.

## Operation
- EEW code = vsew + 1 if widening=1, vsew + 2 if widening=2, else vsew.
  - Codes 0, 1, 2 give 8, 16, 32 bits.
  - Any code above 2, vsew=3, or widening=3 is treated as 32b and pulses eew_err.
- The width configuration is latched only when an element is accepted in state IDLE. While in FILL, the vsew and widening inputs are ignored.
- State machine:
  - IDLE: no partial word.
  - FILL: partial word held, slot counter slot = 1..3.
- Element acceptance: `in_valid & in_ready`.
  - The element is written to slot `slot` of the accumulator.
    - 8b: bytes [8·slot +: 8], be bit slot.
    - 16b: bytes [16·slot +: 16], be bits {2slot+1, 2slot}.
    - 32b: whole word, be = 4'hF.
  - The word completes when the slot reaches the last position (3 for 8b, 1 for 16b, 0 for 32b) or in_last=1.
  - On completion: the accumulator plus the new element move to the output register, out_last = in_last, slot returns to 0, state returns to IDLE.
  - Otherwise: slot increments and state becomes FILL.
- in_ready = ~out_valid | out_ready. This rule holds even for non-completing elements, to keep the handshake simple.
- Output register:
  - out_valid is set on completion.
  - out_valid is cleared on `out_valid & out_ready` without a simultaneous completion.
  - Completion and output handshake in the same cycle: the new word loads and out_valid stays 1.
- Unused bytes of a partial word: out_data bytes are 0 and out_be bits are 0.
- flush has priority over everything. Next edge: state IDLE, slot 0, accumulator 0, out_valid 0. Any element presented in the flush cycle is dropped.

## Timing
- Reset values: out_valid 0, out_data 0, out_be 0, out_last 0, eew_err 0, state IDLE, slot 0. in_ready is 1 during and after reset.
- Latency: the word appears at out_valid on the edge after the completing element is accepted (1 cycle).
- Throughput: one element per cycle while out_ready=1. A full 8b word therefore appears every 4 cycles, 16b every 2, 32b every cycle.
- Stall: out_valid=1 with out_ready=0 holds out_data, out_be and out_last stable and forces in_ready=0. The accumulator is unchanged.
- Reset asserted mid-operation discards the partial and the output word immediately (asynchronous).
- eew_err is asserted on the cycle after the offending latch, for one cycle.

## Test plan
- 8b stream: vsew=0, widening=0, elements 0x11, 0x22, 0x33, 0x44, none with in_last, out_ready=1.
  - Required: one word 0x44332211, be=F, out_last=0, appearing 1 cycle after the 4th element.
- Widening 8b→16b with a last element: vsew=0, widening=1, elements 0xAAAA, 0xBBBB, 0xCCCC (last).
  - Required: word 0xBBBBAAAA be=F, then word 0x0000CCCC be=3 out_last=1.
- Back-pressure with overlap: 32b, out_ready=0 for 3 cycles while in_valid=1.
  - Required: in_ready=0 for those cycles and out_data held.
  - Required: on out_ready=1, the next element is accepted and out_valid stays 1 across the handshake.
- Illegal width: vsew=2, widening=2, element 0xDEADBEEF.
  - Required: eew_err pulses once, output 0xDEADBEEF be=F.
  - Required: vsew changes mid-FILL are ignored; the 8b group latched earlier stays 8b.
- Flush/reset: two 8b elements 0x01, 0x02, then flush=1, then element 0x03 (last).
  - Required: only the word 0x00000003 be=1 out_last=1 appears.
  - Repeat with n_reset pulsed low instead: same output, and all outputs read 0 during reset.
